// File: rtl/shift_seq_ctrl.sv
// ============================================================================
// Module   : shift_seq_ctrl
// Brief    : Arms on a sync_state rising edge, waits cfg_delay+1 cycles, then
//            drives a burst of sh_en cycles with an index, pulses done, and
//            waits in holdoff for sync_state to return low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_ctrl #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sync_state,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_len,
  output logic             sh_en,
  output logic [CNT_W-1:0] bit_idx,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             aborted
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_delay   = 3'd1;
  localparam logic [2:0] c_shift   = 3'd2;
  localparam logic [2:0] c_done    = 3'd3;
  localparam logic [2:0] c_holdoff = 3'd4;

  logic [2:0]       r_state;
  logic             r_sync_prev;
  logic             r_wait_low;
  logic [CNT_W-1:0] r_dly_cnt;
  logic [CNT_W-1:0] r_len;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_sh_en;
  logic [CNT_W-1:0] r_bit_idx;
  logic             r_done;
  logic             r_aborted;
  logic             r_err;

  logic             w_start;
  logic             w_last;
  logic [CNT_W-1:0] w_len_eff;

  // r_wait_low blocks a start until sync_state has been seen low after reset,
  // so a level already high at reset release is not mistaken for an edge.
  assign w_start   = (r_state == c_idle) && sync_state && !r_sync_prev
                     && enable && !r_wait_low;
  assign w_len_eff = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
  assign w_last    = (r_bit_idx == (r_len - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_sync_prev <= 1'b0;
      r_wait_low  <= 1'b1;
      r_dly_cnt   <= '0;
      r_len       <= '0;
      r_to_cnt    <= '0;
      r_sh_en     <= 1'b0;
      r_bit_idx   <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sync_prev <= sync_state;
      if (!sync_state) r_wait_low <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;

      case (r_state)
        c_idle: begin
          if (w_start) begin
            r_state   <= c_delay;
            r_dly_cnt <= cfg_delay;
            r_len     <= w_len_eff;
          end
        end

        c_delay: begin
          if (!enable) begin
            r_state   <= c_holdoff;
            r_aborted <= 1'b1;
            r_to_cnt  <= '0;
          end else if (r_dly_cnt == '0) begin
            r_state   <= c_shift;
            r_sh_en   <= 1'b1;
            r_bit_idx <= '0;
          end else begin
            r_dly_cnt <= r_dly_cnt - CNT_W'(1);
          end
        end

        c_shift: begin
          if (!enable) begin
            r_state   <= c_holdoff;
            r_sh_en   <= 1'b0;
            r_aborted <= 1'b1;
            r_to_cnt  <= '0;
          end else if (w_last) begin
            r_state <= c_done;
            r_sh_en <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_bit_idx <= r_bit_idx + CNT_W'(1);
          end
        end

        c_done: begin
          r_state  <= c_holdoff;
          r_to_cnt <= '0;
        end

        c_holdoff: begin
          if (!sync_state) begin
            r_state <= c_idle;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            r_state <= c_idle;
            r_err   <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        default: begin
          r_state <= c_idle;
          r_sh_en <= 1'b0;
        end
      endcase
    end
  end

  assign sh_en       = r_sh_en;
  assign bit_idx     = r_bit_idx;
  assign busy        = (r_state != c_idle);
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign err_timeout = r_err;

endmodule

`default_nettype wire

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the delay and length configuration fields and the bit index.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum HOLDOFF cycles allowed for sync_state to return low.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: arms the controller; low aborts any sequence.
REQ-006 The block SHALL have port sync_state, input, 1 bit: ACTIVE indication from the RF-input synchroniser FSM.
REQ-007 The block SHALL have port cfg_delay, input, CNT_W bits: cycles to wait, minus one, before shifting.
REQ-008 The block SHALL have port cfg_len, input, CNT_W bits: number of shift cycles; 0 is treated as 1.
REQ-009 The block SHALL have port sh_en, output, 1 bit: shift enable to the shift register and synchroniser FSM.
REQ-010 The block SHALL have port bit_idx, output, CNT_W bits: index of the current shift cycle.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of the shift burst.
REQ-013 The block SHALL have port err_timeout, output, 1 bit: sticky flag indicating sync_state failed to clear.
REQ-014 The block SHALL have port aborted, output, 1 bit: one-cycle pulse when enable drops mid-sequence.

Function
REQ-015 The block SHALL register sync_state into sync_prev each cycle; a start event SHALL be sync_state=1 AND sync_prev=0 AND enable=1, evaluated in IDLE only.
REQ-016 The FSM SHALL have exactly the states IDLE, DELAY, SHIFT, DONE and HOLDOFF.
REQ-017 On a start event the FSM SHALL go IDLE->DELAY, latching cfg_delay into the delay counter and cfg_len (0 mapped to 1) into a length register; later changes to cfg_* SHALL NOT affect a sequence in progress.
REQ-018 In DELAY the counter SHALL decrement each cycle; when the counter equals 0 the FSM SHALL go to SHIFT, giving cfg_delay+1 cycles between the start edge and the first sh_en high edge.
REQ-019 sh_en SHALL be a flop output that is high exactly while in SHIFT, for exactly the latched length L cycles.
REQ-020 bit_idx SHALL be 0 on SHIFT entry and increment by 1 per SHIFT cycle; on the edge where bit_idx==L-1 the FSM SHALL go to DONE, and bit_idx SHALL hold its last value until the next SHIFT entry.
REQ-021 In DONE, done SHALL be high for exactly one cycle, and the FSM SHALL then go to HOLDOFF.
REQ-022 In HOLDOFF the FSM SHALL return to IDLE on the first cycle sync_state=0.
REQ-023 If sync_state is still 1 after TIMEOUT HOLDOFF cycles, the block SHALL set err_timeout and go to IDLE; err_timeout SHALL clear only on reset.
REQ-024 When enable=0 in DELAY or SHIFT, the FSM SHALL go to HOLDOFF on the next edge with sh_en low and aborted pulsed for one cycle; done SHALL NOT pulse.
REQ-025 When enable=0 in DONE or HOLDOFF, the sequence SHALL complete normally.
REQ-026 sync_state edges outside IDLE SHALL be ignored; a sequence SHALL NOT restart until IDLE observes a fresh rising edge.
REQ-027 The counters SHALL NOT wrap: L=2^CNT_W-1 SHALL yield that many sh_en cycles.

Reset
REQ-028 While rst_n=0 the block SHALL asynchronously force state=IDLE, sh_en=0, bit_idx=0, busy=0, done=0, aborted=0, err_timeout=0, sync_prev=0 and the counters to 0.
REQ-029 On rst_n assertion mid-SHIFT, sh_en SHALL drop immediately without a clock edge.
REQ-030 After rst_n release with sync_state already 1, the block SHALL NOT start until sync_state goes low and then high again.

Verification
REQ-031 The bench SHALL cover nominal operation: enable=1, cfg_delay=3, cfg_len=5, sync_state rising -> sh_en high 4 cycles after the start edge for exactly 5 cycles, bit_idx 0..4, done one pulse, busy low after sync_state falls.
REQ-032 The bench SHALL cover boundary configuration: cfg_delay=0, cfg_len=0 -> sh_en high for exactly 1 cycle, 1 cycle after the start edge.
REQ-033 The bench SHALL cover abort: enable dropped on the 3rd SHIFT cycle with cfg_len=8 -> sh_en low on the next edge, aborted one pulse, no done pulse.
REQ-034 The bench SHALL cover timeout: sync_state held at 1 after DONE with TIMEOUT=16 -> err_timeout set after 16 HOLDOFF cycles, state IDLE, no restart while sync_state stays 1.
REQ-035 The bench SHALL cover reset mid-SHIFT: rst_n pulsed low -> all outputs 0 asynchronously; no start until a new sync_state rising edge.
REQ-036 The bench SHALL cover config change mid-sequence: cfg_len changed from 5 to 2 during DELAY -> 5 sh_en cycles.
